// File: rtl/rv32i_lsu.sv
// Memory-access stage of the rv32i pipeline: runs pipelined-Wishbone load/store
// cycles and forwards every other instruction to writeback one cycle later.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif
`ifndef LOAD
`define LOAD 2
`endif
`ifndef STORE
`define STORE 3
`endif

module rv32i_lsu (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [31:0]                 i_y,
    input  logic [31:0]                 i_rs2,
    input  logic [2:0]                  i_funct3,
    input  logic [`OPCODE_WIDTH-1:0]    i_opcode,
    input  logic [`EXCEPTION_WIDTH-1:0] i_exception,
    input  logic [31:0]                 i_pc,
    input  logic [4:0]                  i_rd_addr,
    input  logic [31:0]                 i_rd,
    input  logic                        i_rd_valid,
    input  logic                        i_wr_rd,
    input  logic                        i_ce,
    input  logic                        i_stall_from_alu,
    input  logic                        i_stall,
    input  logic                        i_flush,
    output logic                        o_wb_cyc,
    output logic                        o_wb_stb,
    output logic                        o_wb_we,
    output logic [31:0]                 o_wb_addr,
    output logic [31:0]                 o_wb_data,
    output logic [3:0]                  o_wb_sel,
    input  logic                        i_wb_ack,
    input  logic                        i_wb_stall,
    input  logic [31:0]                 i_wb_data,
    output logic [4:0]                  o_rd_addr,
    output logic [31:0]                 o_rd,
    output logic                        o_rd_valid,
    output logic                        o_wr_rd,
    output logic [31:0]                 o_data_load,
    output logic [31:0]                 o_pc,
    output logic [`OPCODE_WIDTH-1:0]    o_opcode,
    output logic [2:0]                  o_funct3,
    output logic [`EXCEPTION_WIDTH-1:0] o_exception,
    output logic                        o_misaligned,
    output logic                        o_ce,
    output logic                        o_stall,
    output logic                        o_flush
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                      state_q, state_d;
    logic                        we_q, we_d;
    logic [31:0]                 wb_addr_q, wb_addr_d;
    logic [31:0]                 wb_data_q, wb_data_d;
    logic [3:0]                  wb_sel_q, wb_sel_d;
    logic [1:0]                  addr_lo_q, addr_lo_d;
    logic [4:0]                  rd_addr_q, rd_addr_d;
    logic [31:0]                 rd_q, rd_d;
    logic                        rd_valid_q, rd_valid_d;
    logic                        wr_rd_q, wr_rd_d;
    logic [31:0]                 data_load_q, data_load_d;
    logic [31:0]                 pc_q, pc_d;
    logic [`OPCODE_WIDTH-1:0]    opcode_q, opcode_d;
    logic [2:0]                  funct3_q, funct3_d;
    logic [`EXCEPTION_WIDTH-1:0] exception_q, exception_d;
    logic                        misaligned_q, misaligned_d;
    logic                        ce_q, ce_d;
    logic                        flushed_q, flushed_d;

    logic        is_mem, is_store, misalign, accept, ack_take;
    logic [31:0] st_data, ld_data;
    logic [3:0]  st_sel;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign is_store = i_opcode[`STORE];
    assign is_mem   = i_opcode[`LOAD] | i_opcode[`STORE];
    assign misalign = ((i_funct3[1:0] == 2'b01) && i_y[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_y[1:0] != 2'b00));
    assign accept   = i_ce && !i_stall && !i_flush;
    assign ack_take = i_wb_ack && (((state_q == REQ) && !i_wb_stall) || (state_q == WAIT));

    always_comb begin
        st_data = i_rs2;
        st_sel  = 4'b1111;
        case (i_funct3[1:0])
            2'b00: begin
                st_data = {4{i_rs2[7:0]}};
                st_sel  = 4'b0001 << i_y[1:0];
            end
            2'b01: begin
                st_data = {2{i_rs2[15:0]}};
                st_sel  = 4'b0011 << {i_y[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = i_wb_data[7:0];
        case (addr_lo_q)
            2'b01:   ld_byte = i_wb_data[15:8];
            2'b10:   ld_byte = i_wb_data[23:16];
            2'b11:   ld_byte = i_wb_data[31:24];
            default: ;
        endcase
        ld_half = addr_lo_q[1] ? i_wb_data[31:16] : i_wb_data[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'b0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'b0, ld_half};
            default: ld_data = i_wb_data;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        wb_sel_d     = wb_sel_q;
        addr_lo_d    = addr_lo_q;
        rd_addr_d    = rd_addr_q;
        rd_d         = rd_q;
        rd_valid_d   = rd_valid_q;
        wr_rd_d      = wr_rd_q;
        data_load_d  = data_load_q;
        pc_d         = pc_q;
        opcode_d     = opcode_q;
        funct3_d     = funct3_q;
        exception_d  = exception_q;
        misaligned_d = misaligned_q;
        ce_d         = ce_q;
        flushed_d    = flushed_q;

        case (state_q)
            IDLE: begin
                flushed_d = 1'b0;
                // a pending passthrough result is held only while downstream stalls
                if (i_flush || !i_stall) ce_d = 1'b0;
                if (accept) begin
                    pc_d         = i_pc;
                    opcode_d     = i_opcode;
                    funct3_d     = i_funct3;
                    exception_d  = i_exception;
                    rd_addr_d    = i_rd_addr;
                    rd_d         = i_rd;
                    addr_lo_d    = i_y[1:0];
                    misaligned_d = is_mem && misalign;
                    if (!is_mem) begin
                        ce_d       = 1'b1;
                        wr_rd_d    = i_wr_rd;
                        rd_valid_d = i_rd_valid;
                    end else if (misalign) begin
                        ce_d       = 1'b1;
                        wr_rd_d    = 1'b0;
                        rd_valid_d = 1'b0;
                    end else begin
                        wb_addr_d  = {i_y[31:2], 2'b00};
                        wb_data_d  = st_data;
                        wb_sel_d   = st_sel;
                        we_d       = is_store;
                        wr_rd_d    = is_store ? 1'b0 : i_wr_rd;
                        rd_valid_d = !is_store;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (i_flush) flushed_d = 1'b1;
                if (!i_wb_stall) state_d = i_wb_ack ? DONE : WAIT;
            end
            WAIT: begin
                if (i_flush) flushed_d = 1'b1;
                if (i_wb_ack) state_d = DONE;
            end
            DONE: begin
                if (!i_stall) begin
                    state_d   = IDLE;
                    flushed_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ack_take) data_load_d = ld_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            wb_sel_q     <= '0;
            addr_lo_q    <= '0;
            rd_addr_q    <= '0;
            rd_q         <= '0;
            rd_valid_q   <= 1'b0;
            wr_rd_q      <= 1'b0;
            data_load_q  <= '0;
            pc_q         <= '0;
            opcode_q     <= '0;
            funct3_q     <= '0;
            exception_q  <= '0;
            misaligned_q <= 1'b0;
            ce_q         <= 1'b0;
            flushed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            wb_sel_q     <= wb_sel_d;
            addr_lo_q    <= addr_lo_d;
            rd_addr_q    <= rd_addr_d;
            rd_q         <= rd_d;
            rd_valid_q   <= rd_valid_d;
            wr_rd_q      <= wr_rd_d;
            data_load_q  <= data_load_d;
            pc_q         <= pc_d;
            opcode_q     <= opcode_d;
            funct3_q     <= funct3_d;
            exception_q  <= exception_d;
            misaligned_q <= misaligned_d;
            ce_q         <= ce_d;
            flushed_q    <= flushed_d;
        end
    end

    // bus strobes decode from state so an async reset drops them immediately
    assign o_wb_cyc     = (state_q == REQ) || (state_q == WAIT);
    assign o_wb_stb     = (state_q == REQ);
    assign o_wb_we      = we_q;
    assign o_wb_addr    = wb_addr_q;
    assign o_wb_data    = wb_data_q;
    assign o_wb_sel     = wb_sel_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_rd         = rd_q;
    assign o_rd_valid   = rd_valid_q;
    assign o_wr_rd      = wr_rd_q;
    assign o_data_load  = data_load_q;
    assign o_pc         = pc_q;
    assign o_opcode     = opcode_q;
    assign o_funct3     = funct3_q;
    assign o_exception  = exception_q;
    assign o_misaligned = misaligned_q;
    assign o_ce         = ce_q || ((state_q == DONE) && !flushed_q);
    assign o_stall      = i_stall || ((state_q == IDLE) && i_ce && i_stall_from_alu) ||
                          (state_q == REQ) || (state_q == WAIT);
    assign o_flush      = i_flush;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Scoreboard bench for rv32i_lsu: expectations queued at issue, popped when o_ce fires.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif

module tb_rv32i_lsu;
    localparam logic [`OPCODE_WIDTH-1:0] OP_RTYPE = 1;
    localparam logic [`OPCODE_WIDTH-1:0] OP_LOAD  = 4;
    localparam logic [`OPCODE_WIDTH-1:0] OP_STORE = 8;

    logic i_clk = 0, i_rst = 0;
    logic [31:0] i_y = 0, i_rs2 = 0, i_pc = 0, i_rd = 0, i_wb_data = 0;
    logic [2:0] i_funct3 = 0;
    logic [`OPCODE_WIDTH-1:0] i_opcode = 0;
    logic [`EXCEPTION_WIDTH-1:0] i_exception = 0;
    logic [4:0] i_rd_addr = 0;
    logic i_rd_valid = 0, i_wr_rd = 0, i_ce = 0, i_stall_from_alu = 0, i_stall = 0, i_flush = 0;
    logic i_wb_ack = 0, i_wb_stall = 0;
    logic o_wb_cyc, o_wb_stb, o_wb_we, o_rd_valid, o_wr_rd, o_misaligned, o_ce, o_stall, o_flush;
    logic [31:0] o_wb_addr, o_wb_data, o_rd, o_data_load, o_pc;
    logic [3:0] o_wb_sel;
    logic [4:0] o_rd_addr;
    logic [`OPCODE_WIDTH-1:0] o_opcode;
    logic [2:0] o_funct3;
    logic [`EXCEPTION_WIDTH-1:0] o_exception;

    typedef struct {
        logic [31:0] rd;
        logic        wr_rd;
        logic        mis;
        logic        is_load;
        logic [31:0] load;
        logic [31:0] pc;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    rv32i_lsu dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_y(i_y), .i_rs2(i_rs2), .i_funct3(i_funct3),
        .i_opcode(i_opcode), .i_exception(i_exception), .i_pc(i_pc), .i_rd_addr(i_rd_addr),
        .i_rd(i_rd), .i_rd_valid(i_rd_valid), .i_wr_rd(i_wr_rd), .i_ce(i_ce),
        .i_stall_from_alu(i_stall_from_alu), .i_stall(i_stall), .i_flush(i_flush),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
        .i_wb_data(i_wb_data), .o_rd_addr(o_rd_addr), .o_rd(o_rd), .o_rd_valid(o_rd_valid),
        .o_wr_rd(o_wr_rd), .o_data_load(o_data_load), .o_pc(o_pc), .o_opcode(o_opcode),
        .o_funct3(o_funct3), .o_exception(o_exception), .o_misaligned(o_misaligned),
        .o_ce(o_ce), .o_stall(o_stall), .o_flush(o_flush)
    );

    // Issue one non-memory instruction; o_ce must pulse exactly one cycle later.
    task automatic run_alu(input string name, input logic [31:0] rd, input logic [4:0] rda,
                           input logic wr, input logic [31:0] pc);
        exp_t e;
        @(negedge i_clk);
        i_ce = 1; i_stall_from_alu = 0; i_opcode = OP_RTYPE; i_funct3 = 0; i_y = 32'h0;
        i_rd = rd; i_rd_addr = rda; i_wr_rd = wr; i_rd_valid = 1; i_pc = pc;
        sbq.push_back('{rd: rd, wr_rd: wr, mis: 1'b0, is_load: 1'b0, load: 32'h0, pc: pc});
        @(negedge i_clk);
        i_ce = 0;
        checks++;
        if (o_ce !== 1'b1) begin failures++; $display("FAIL %s ce: got %b want 1", name, o_ce); end
        else begin
            e = sbq.pop_front();
            checks++;
            if (o_rd !== e.rd || o_wr_rd !== e.wr_rd || o_pc !== e.pc || o_misaligned !== e.mis ||
                o_rd_addr !== rda) begin
                failures++;
                $display("FAIL %s fields: got rd=%h wr=%b pc=%h mis=%b ra=%0d want rd=%h wr=%b pc=%h mis=%b ra=%0d",
                         name, o_rd, o_wr_rd, o_pc, o_misaligned, o_rd_addr, e.rd, e.wr_rd, e.pc, e.mis, rda);
            end
        end
        checks++;
        if (o_wb_cyc !== 1'b0) begin failures++; $display("FAIL %s cyc: got %b want 0", name, o_wb_cyc); end
        @(negedge i_clk);
        checks++;
        if (o_ce !== 1'b0) begin failures++; $display("FAIL %s ce_pulse: got %b want 0", name, o_ce); end
    endtask

    // Misaligned load/store: no bus cycle, misaligned flag with o_ce one cycle later.
    task automatic run_mis(input string name, input logic st, input logic [2:0] f3, input logic [31:0] addr);
        exp_t e;
        @(negedge i_clk);
        i_ce = 1; i_stall_from_alu = 1; i_opcode = st ? OP_STORE : OP_LOAD; i_funct3 = f3; i_y = addr;
        i_rd = 32'h1111_2222; i_rd_addr = 5'd9; i_wr_rd = !st; i_rd_valid = !st; i_pc = addr + 32'h100;
        sbq.push_back('{rd: 32'h1111_2222, wr_rd: 1'b0, mis: 1'b1, is_load: 1'b0, load: 32'h0, pc: addr + 32'h100});
        @(negedge i_clk);
        i_ce = 0; i_stall_from_alu = 0;
        checks++;
        if (o_ce !== 1'b1 || o_wb_cyc !== 1'b0) begin
            failures++; $display("FAIL %s ce/cyc: got ce=%b cyc=%b want ce=1 cyc=0", name, o_ce, o_wb_cyc);
        end else begin
            e = sbq.pop_front();
            checks++;
            if (o_misaligned !== e.mis || o_wr_rd !== e.wr_rd || o_pc !== e.pc) begin
                failures++;
                $display("FAIL %s fields: got mis=%b wr=%b pc=%h want mis=%b wr=%b pc=%h",
                         name, o_misaligned, o_wr_rd, o_pc, e.mis, e.wr_rd, e.pc);
            end
        end
        @(negedge i_clk);
        checks++;
        if (o_wb_cyc !== 1'b0 || o_ce !== 1'b0) begin
            failures++; $display("FAIL %s after: got cyc=%b ce=%b want 0 0", name, o_wb_cyc, o_ce);
        end
    endtask

    // Aligned load/store through the bus. stall_n cycles of wb_stall in REQ, ack arrives
    // gap cycles after stb is taken (0 = same cycle), optional flush in WAIT and
    // hold_n cycles of downstream stall in DONE.
    task automatic run_mem(input string name, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                           input int stall_n, input int gap, input bit flush_wait, input int hold_n,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_sel,
                           input logic [31:0] exp_load);
        int stb_cycles;
        exp_t e;
        @(negedge i_clk);
        i_ce = 1; i_stall_from_alu = 1; i_opcode = st ? OP_STORE : OP_LOAD; i_funct3 = f3;
        i_y = addr; i_rs2 = rs2; i_rd = 32'h0BAD_0000; i_rd_addr = 5'd7;
        i_wr_rd = !st; i_rd_valid = !st; i_pc = addr ^ 32'hA5A5_0000;
        if (!flush_wait)
            sbq.push_back('{rd: 32'h0BAD_0000, wr_rd: !st, mis: 1'b0, is_load: !st,
                            load: exp_load, pc: addr ^ 32'hA5A5_0000});
        #1;
        checks++;
        if (o_stall !== 1'b1) begin failures++; $display("FAIL %s stall_accept: got %b want 1", name, o_stall); end
        @(negedge i_clk);
        i_ce = 0; i_stall_from_alu = 0;
        checks++;
        if (o_wb_addr !== {addr[31:2], 2'b00} || o_wb_sel !== exp_sel || o_wb_we !== st ||
            (st && o_wb_data !== exp_wdata)) begin
            failures++;
            $display("FAIL %s bus: got addr=%h sel=%b we=%b data=%h want addr=%h sel=%b we=%b data=%h",
                     name, o_wb_addr, o_wb_sel, o_wb_we, o_wb_data, {addr[31:2], 2'b00}, exp_sel, st, exp_wdata);
        end
        stb_cycles = 0;
        for (int s = 0; s < stall_n; s++) begin
            i_wb_stall = 1;
            if (o_wb_stb === 1'b1 && o_wb_cyc === 1'b1 && o_stall === 1'b1) stb_cycles++;
            @(negedge i_clk);
        end
        i_wb_stall = 0;
        if (gap == 0) begin i_wb_ack = 1; i_wb_data = rdata; end
        if (o_wb_stb === 1'b1 && o_wb_cyc === 1'b1 && o_stall === 1'b1) stb_cycles++;
        @(negedge i_clk);
        i_wb_ack = 0;
        checks++;
        if (stb_cycles !== stall_n + 1) begin
            failures++; $display("FAIL %s stb_cycles: got %0d want %0d", name, stb_cycles, stall_n + 1);
        end
        if (gap > 0) begin
            for (int g = 1; g < gap; g++) begin
                i_flush = (flush_wait && g == 1);
                #1;
                checks++;
                if (o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b0 || o_stall !== 1'b1 || o_flush !== i_flush) begin
                    failures++;
                    $display("FAIL %s wait: got cyc=%b stb=%b stall=%b flush=%b want 1 0 1 %b",
                             name, o_wb_cyc, o_wb_stb, o_stall, o_flush, i_flush);
                end
                @(negedge i_clk);
            end
            i_flush = 0;
            i_wb_ack = 1; i_wb_data = rdata;
            checks++;
            if (o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b0 || o_stall !== 1'b1) begin
                failures++;
                $display("FAIL %s ack_cycle: got cyc=%b stb=%b stall=%b want 1 0 1", name, o_wb_cyc, o_wb_stb, o_stall);
            end
            @(negedge i_clk);
            i_wb_ack = 0; i_wb_data = 32'h0;
        end
        checks++;
        if (o_wb_cyc !== 1'b0 || o_stall !== 1'b0) begin
            failures++; $display("FAIL %s done_bus: got cyc=%b stall=%b want 0 0", name, o_wb_cyc, o_stall);
        end
        checks++;
        if (flush_wait) begin
            if (o_ce !== 1'b0) begin failures++; $display("FAIL %s flushed_ce: got %b want 0", name, o_ce); end
        end else if (o_ce !== 1'b1) begin
            failures++; $display("FAIL %s done_ce: got %b want 1", name, o_ce);
        end else begin
            e = sbq.pop_front();
            checks++;
            if (o_wr_rd !== e.wr_rd || o_rd !== e.rd || o_pc !== e.pc || o_misaligned !== e.mis ||
                (e.is_load && (o_data_load !== e.load || o_rd_valid !== 1'b1))) begin
                failures++;
                $display("FAIL %s result: got load=%h wr=%b rv=%b pc=%h want load=%h wr=%b rv=1 pc=%h",
                         name, o_data_load, o_wr_rd, o_rd_valid, o_pc, e.load, e.wr_rd, e.pc);
            end
        end
        if (hold_n > 0) begin
            i_stall = 1;
            for (int h = 0; h < hold_n; h++) begin
                @(negedge i_clk);
                checks++;
                if (o_ce !== 1'b1 || o_stall !== 1'b1 || (!st && o_data_load !== exp_load)) begin
                    failures++;
                    $display("FAIL %s hold: got ce=%b stall=%b load=%h want 1 1 %h", name, o_ce, o_stall, o_data_load, exp_load);
                end
            end
            i_stall = 0;
        end
        @(negedge i_clk);
        checks++;
        if (o_ce !== 1'b0 || o_wb_cyc !== 1'b0) begin
            failures++; $display("FAIL %s idle_after: got ce=%b cyc=%b want 0 0", name, o_ce, o_wb_cyc);
        end
    endtask

    task automatic test_reset();
        i_rst = 1;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_wb_cyc !== 0 || o_wb_stb !== 0 || o_wb_we !== 0 || o_ce !== 0 || o_wr_rd !== 0 ||
            o_rd_valid !== 0 || o_misaligned !== 0 || o_stall !== 0) begin
            failures++; $display("FAIL reset_ctrl: got cyc=%b stb=%b we=%b ce=%b wr=%b rv=%b mis=%b stall=%b want all 0",
                                 o_wb_cyc, o_wb_stb, o_wb_we, o_ce, o_wr_rd, o_rd_valid, o_misaligned, o_stall);
        end
        checks++;
        if (o_wb_addr !== 0 || o_wb_data !== 0 || o_wb_sel !== 0 || o_rd !== 0 || o_data_load !== 0 ||
            o_pc !== 0 || o_opcode !== 0 || o_funct3 !== 0 || o_exception !== 0 || o_rd_addr !== 0) begin
            failures++; $display("FAIL reset_data: got addr=%h data=%h sel=%b rd=%h load=%h pc=%h want all 0",
                                 o_wb_addr, o_wb_data, o_wb_sel, o_rd, o_data_load, o_pc);
        end
        i_rst = 0;
    endtask

    task automatic test_passthrough();
        run_alu("add", 32'h0000_0005, 5'd3, 1'b1, 32'h0000_0040);
        run_alu("alu_nowr", 32'hDEAD_0001, 5'd12, 1'b0, 32'h0000_0044);
        // stalled or flushed instructions are not accepted
        @(negedge i_clk);
        i_ce = 1; i_opcode = OP_RTYPE; i_stall = 1;
        @(negedge i_clk);
        checks++;
        if (o_ce !== 1'b0) begin failures++; $display("FAIL stall_noaccept: got ce=%b want 0", o_ce); end
        i_stall = 0; i_flush = 1;
        @(negedge i_clk);
        checks++;
        if (o_ce !== 1'b0 || o_flush !== 1'b1) begin
            failures++; $display("FAIL flush_idle: got ce=%b flush=%b want 0 1", o_ce, o_flush);
        end
        i_ce = 0; i_flush = 0;
    endtask

    task automatic test_loads();
        run_mem("lb",  1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF11, 0, 2, 1'b0, 0, 32'h0, 4'b1000, 32'hFFFF_FF80);
        run_mem("lbu", 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_FF11, 0, 1, 1'b0, 0, 32'h0, 4'b1000, 32'h0000_0080);
        run_mem("lh",  1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h80FF_FF11, 0, 1, 1'b0, 0, 32'h0, 4'b1100, 32'hFFFF_80FF);
        run_mem("lhu", 1'b0, 3'b101, 32'h0000_1000, 32'h0, 32'h80FF_FF11, 0, 1, 1'b0, 0, 32'h0, 4'b0011, 32'h0000_FF11);
        run_mem("lw",  1'b0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 1, 1'b0, 0, 32'h0, 4'b1111, 32'hDEAD_BEEF);
    endtask

    task automatic test_stores();
        run_mem("sh", 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0, 1, 1'b0, 0, 32'hABCD_ABCD, 4'b1100, 32'h0);
        run_mem("sb", 1'b1, 3'b000, 32'h0000_2001, 32'h0000_0055, 32'h0, 0, 1, 1'b0, 0, 32'h5555_5555, 4'b0010, 32'h0);
        run_mem("sw", 1'b1, 3'b010, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 0, 1, 1'b0, 0, 32'hCAFE_F00D, 4'b1111, 32'h0);
    endtask

    task automatic test_bus_timing();
        run_mem("wb_stall3", 1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h0102_0304, 3, 1, 1'b0, 0, 32'h0, 4'b1111, 32'h0102_0304);
        run_mem("ack_with_stb", 1'b0, 3'b001, 32'h0000_3002, 32'h0, 32'h7FFF_0000, 0, 0, 1'b0, 0, 32'h0, 4'b1100, 32'h0000_7FFF);
        run_mem("done_hold", 1'b0, 3'b000, 32'h0000_3001, 32'h0, 32'h0000_9900, 0, 1, 1'b0, 2, 32'h0, 4'b0010, 32'hFFFF_FF99);
    endtask

    task automatic test_misaligned();
        run_mis("lw_mis", 1'b0, 3'b010, 32'h0000_1001);
        run_mis("sh_mis", 1'b1, 3'b001, 32'h0000_2003);
        run_mis("lhu_mis", 1'b0, 3'b101, 32'h0000_1001);
    endtask

    task automatic test_flush_and_reset();
        run_mem("flush_wait", 1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h1234_5678, 0, 3, 1'b1, 0, 32'h0, 4'b1111, 32'h0);
        @(negedge i_clk);
        i_ce = 1; i_stall_from_alu = 1; i_opcode = OP_LOAD; i_funct3 = 3'b010; i_y = 32'h0000_5000;
        @(negedge i_clk);
        i_ce = 0; i_stall_from_alu = 0;
        @(negedge i_clk);
        checks++;
        if (o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b0) begin
            failures++; $display("FAIL rst_wait_pre: got cyc=%b stb=%b want 1 0", o_wb_cyc, o_wb_stb);
        end
        #2 i_rst = 1;
        #1;
        checks++;
        if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0 || o_stall !== 1'b0 || o_ce !== 1'b0) begin
            failures++; $display("FAIL rst_wait: got cyc=%b stb=%b stall=%b ce=%b want 0 0 0 0",
                                 o_wb_cyc, o_wb_stb, o_stall, o_ce);
        end
        @(negedge i_clk);
        i_rst = 0;
        i_wb_ack = 1;
        @(negedge i_clk);
        i_wb_ack = 0;
        checks++;
        if (o_ce !== 1'b0 || o_wb_cyc !== 1'b0) begin
            failures++; $display("FAIL ack_in_idle: got ce=%b cyc=%b want 0 0", o_ce, o_wb_cyc);
        end
    endtask

    task automatic test_back_to_back();
        run_alu("b2b_alu0", 32'h0000_00AA, 5'd1, 1'b1, 32'h0000_0100);
        run_mem("b2b_lb", 1'b0, 3'b000, 32'h0000_6000, 32'h0, 32'h0000_007F, 0, 1, 1'b0, 0, 32'h0, 4'b0001, 32'h0000_007F);
        run_alu("b2b_alu1", 32'h0000_00BB, 5'd2, 1'b1, 32'h0000_0108);
        checks++;
        if (sbq.size() !== 0) begin failures++; $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size()); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_loads();
        test_stores();
        test_bus_timing();
        test_misaligned();
        test_flush_and_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion want finish");
        $fatal(1, "timeout");
    end
endmodule
